// File: rtl/dreg_pkg.sv
// Shared constants and helpers for the dreg pipeline.
package dreg_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int p = 1; p < value; p = p * 2) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dreg_pipe_stage.sv
// One pipeline slot: a data register plus its valid bit, with a local ready term.
module dreg_pipe_stage
  import dreg_pkg::*;
#(
  parameter int              WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  input  logic             rdy_next,
  output logic             rdy,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // An empty slot always accepts, which is what lets words collapse bubbles.
  assign rdy = !valid | rdy_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (rdy) begin
      valid <= prev_valid;
      if (prev_valid) begin
        data <= prev_data;
      end
    end
  end

endmodule

// File: rtl/dreg_pipe_sync.sv
// Back-pressurable register pipeline: DEPTH stages with a ready chain and occupancy count.
module dreg_pipe_sync
  import dreg_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = clog2(DEPTH + 1);

  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] valid_s;
  logic [WIDTH-1:0] data_s [DEPTH];
  logic             in_fire;
  logic             out_fire;

  assign rdy[DEPTH] = out_ready;
  assign in_ready   = rdy[0] & !flush & !reset;
  assign in_fire    = in_valid & in_ready;
  assign out_valid  = valid_s[DEPTH-1];
  assign out_data   = data_s[DEPTH-1];
  assign out_fire   = out_valid & out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             prev_valid;
    logic [WIDTH-1:0] prev_data;

    if (i == 0) begin : g_head
      assign prev_valid = in_fire;
      assign prev_data  = in_data;
    end else begin : g_body
      assign prev_valid = valid_s[i-1];
      assign prev_data  = data_s[i-1];
    end

    dreg_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .prev_valid (prev_valid),
      .prev_data  (prev_data),
      .rdy_next   (rdy[i+1]),
      .rdy        (rdy[i]),
      .valid      (valid_s[i]),
      .data       (data_s[i])
    );
  end

  // Occupancy tracks handshakes, so it always equals the number of valid stages.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
    end else if (in_fire && !out_fire) begin
      count <= count + CW'(1);
    end else if (out_fire && !in_fire) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_dreg_pipe_sync.sv
// Self-checking bench: vector table for reset/latency, scoreboard for ordering and flow control.
module tb_dreg_pipe_sync;

  localparam int         WIDTH = 8;
  localparam int         DEPTH = 4;
  localparam logic [7:0] RVAL  = 8'hA5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [2:0] count;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] sb [$];
  logic       mon_en = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #5 clk = ~clk;

  dreg_pipe_sync #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (RVAL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  typedef struct {
    logic       r;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       exp_ov;
    logic [2:0] exp_cnt;
    logic       exp_ir;
    logic       chk_od;
    logic [7:0] exp_od;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic iv,
                               input logic [7:0] d, input logic ordy);
    @(posedge clk);
    #1;
    reset     = r;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      k++;
    end
    @(negedge clk);
    checkOutput("drain_done", sb.size(), 0);
  endtask

  // Scoreboard monitor: decisions taken mid-cycle, applied at the next posedge.
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("count_vs_sb", count, sb.size());
      checkOutput("in_ready_model", in_ready,
                  !reset && !flush && ((sb.size() < DEPTH) || out_ready));
      if (prev_stall) begin
        checkOutput("stall_valid", out_valid, 1);
        checkOutput("stall_data", out_data, prev_data);
      end
      prev_stall = out_valid && !out_ready && !reset && !flush;
      prev_data  = out_data;
      if (reset) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_out", out_data, 32'hFFFF_FFFF);
          end else begin
            checkOutput("sb_data", out_data, sb.pop_front());
          end
        end
        if (flush) begin
          sb.delete();
        end else if (in_valid && in_ready) begin
          sb.push_back(in_data);
        end
      end
    end
  end

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, RVAL};
    vecs[1] = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, RVAL};
    vecs[2] = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, RVAL};
    vecs[3] = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, RVAL};
    vecs[4] = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 8'h00};
    vecs[6] = '{1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 8'h01};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 8'h02};
    vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 8'h03};
    vecs[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 8'h03};

    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset holding off input, then first-word latency and a short stall.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].r, 1'b0, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_ov);
      checkOutput($sformatf("vec%0d_count", i), count, vecs[i].exp_cnt);
      checkOutput($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_ir);
      if (vecs[i].chk_od) begin
        checkOutput($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_od);
      end
    end
    drain(20);

    // Back-to-back stream: full throughput, count pinned at DEPTH.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'(i), 1'b1);
      @(negedge clk);
      if (i == 5) begin
        checkOutput("stream_first_out", out_data, 8'h01);
      end
      if (i >= 5) begin
        checkOutput("stream_count", count, DEPTH);
        checkOutput("stream_out_valid", out_valid, 1);
      end
    end
    drain(20);

    // Back-pressure: six offered, four accepted.
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'(i), 1'b0);
    end
    @(negedge clk);
    checkOutput("bp_count", count, DEPTH);
    checkOutput("bp_in_ready", in_ready, 0);
    checkOutput("bp_out_data", out_data, 8'h01);
    drain(20);

    // Bubbles compacting behind a stalled output.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h21, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h22, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h23, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h24, 1'b1);
    drain(20);

    // Flush with an input offered in the same cycle.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h31, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h32, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h33, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h34, 1'b0);
    @(negedge clk);
    checkOutput("flush_count_before", count, 3);
    checkOutput("flush_in_ready", in_ready, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("flush_count_after", count, 0);
    checkOutput("flush_out_valid", out_valid, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h35, 1'b1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("flush_lat%0d_valid", k), out_valid, 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    checkOutput("flush_lat_arrive_valid", out_valid, 1);
    checkOutput("flush_lat_arrive_data", out_data, 8'h35);
    drain(20);

    // Reset while full and stalled.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h41 + i), 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h55, 1'b0);
    @(negedge clk);
    checkOutput("rst_stall_count_before", count, DEPTH);
    checkOutput("rst_stall_in_ready", in_ready, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("rst_stall_count", count, 0);
    checkOutput("rst_stall_out_valid", out_valid, 0);
    checkOutput("rst_stall_out_data", out_data, RVAL);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h45, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h46, 1'b1);
    drain(20);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
